// File: rtl/nmi_demux_bus.sv
// nmi_demux_bus: registered NMI address demultiplexer, one master to NUM_SLV slaves.
// One transaction in flight at a time. Request fields are latched on acceptance and
// broadcast to all slaves, with a one-hot valid. Responses go back through a register.
// Unmapped addresses get an error response carrying ERR_RDATA.
// Optional feature macro: NMI_DEMUX_TIMEOUT_EN. When it is defined, a BUSY-cycle watchdog
// ends a hung slave access with an error response after TIMEOUT_CYC cycles.
module nmi_demux_bus #(
   parameter int                        NUM_SLV     = 8,
   parameter int                        ADDR_W      = 32,
   parameter int                        DATA_W      = 32,
   parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE    = {NUM_SLV{32'h0}},
   parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK    = {NUM_SLV{32'hFF00_0000}},
   parameter int                        TIMEOUT_CYC = 256,
   parameter logic [DATA_W-1:0]         ERR_RDATA   = 32'hDEAD_BEEF
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   // master side
   input  logic                      mst_valid_i,
   input  logic [ADDR_W-1:0]         mst_addr_i,
   input  logic [DATA_W-1:0]         mst_wdata_i,
   input  logic [DATA_W/8-1:0]       mst_wstrb_i,
   output logic [DATA_W-1:0]         mst_rdata_o,
   output logic                      mst_ready_o,
   output logic                      mst_err_o,
   // slave side
   output logic [NUM_SLV-1:0]        slv_valid_o,
   output logic [ADDR_W-1:0]         slv_addr_o,
   output logic [DATA_W-1:0]         slv_wdata_o,
   output logic [DATA_W/8-1:0]       slv_wstrb_o,
   input  logic [NUM_SLV*DATA_W-1:0] slv_rdata_i,
   input  logic [NUM_SLV-1:0]        slv_ready_i
);

   localparam int STRB_W = DATA_W / 8;

   // Parameter sanity checks, evaluated at elaboration.
   if (NUM_SLV < 1 || NUM_SLV > 16) begin : g_bad_num_slv
      $error("nmi_demux_bus: NUM_SLV must be in 1..16");
   end
   if (DATA_W % 8 != 0) begin : g_bad_data_w
      $error("nmi_demux_bus: DATA_W must be a multiple of 8");
   end
   if (TIMEOUT_CYC < 2) begin : g_bad_timeout
      $error("nmi_demux_bus: TIMEOUT_CYC must be >= 2");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_RESP,
      S_ERR
   } state_t;

   state_t              state_q, state_d;
   logic [NUM_SLV-1:0]  match;      // raw per-slave address hits
   logic [NUM_SLV-1:0]  dec_sel;    // lowest-index hit, one-hot
   logic                dec_hit;
   logic [NUM_SLV-1:0]  sel_q;      // slave owning the current transaction
   logic [DATA_W-1:0]   rdata_q;    // response data register, held between pulses
   logic                err_q;      // error flag for a BUSY->RESP exit via watchdog
   logic                sel_ready;  // ready from the selected slave only
   logic [DATA_W-1:0]   sel_rdata;  // read data of the selected slave
   logic                timeout;    // watchdog expiry this cycle

   // Address comparators. Base and mask are constants, so each one is a masked equality.
   for (genvar g = 0; g < NUM_SLV; g++) begin : g_match
      localparam logic [ADDR_W-1:0] M = SLV_MASK[g*ADDR_W +: ADDR_W];
      localparam logic [ADDR_W-1:0] B = SLV_BASE[g*ADDR_W +: ADDR_W] & M;
      assign match[g] = ((mst_addr_i & M) == B);
   end

   // Overlapping entries resolve to the lowest index by isolating the lowest set bit.
   assign dec_sel = match & (~match + NUM_SLV'(1));
   assign dec_hit = |match;

   // Ready from any slave other than the selected one is masked off here.
   assign sel_ready = |(slv_ready_i & sel_q);

   // Read-data mux. It uses AND-OR selection over the one-hot sel_q.
   always_comb begin
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         sel_rdata = sel_rdata | (slv_rdata_i[i*DATA_W +: DATA_W] & {DATA_W{sel_q[i]}});
      end
   end

`ifdef NMI_DEMUX_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC);

   logic [CNT_W-1:0] cnt_q;

   // Expiry is checked on the cycle the counter reaches TIMEOUT_CYC-1.
   // So slave valid is high for exactly TIMEOUT_CYC cycles before the error.
   assign timeout = (state_q == S_BUSY) && !sel_ready && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   // Watchdog counts BUSY cycles and clears whenever BUSY is left or not entered.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (state_q == S_BUSY && !sel_ready && !timeout) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end else begin
         cnt_q <= '0;
      end
   end
`else
   // Without the watchdog, BUSY waits for the selected slave indefinitely.
   assign timeout = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and outputs. Every output comes from registers only, so master
   // inputs and slv_ready_i have no combinational path to any output.
   always_comb begin
      state_d     = state_q;
      mst_ready_o = 1'b0;
      mst_err_o   = 1'b0;
      slv_valid_o = '0;
      case (state_q)
         S_IDLE: begin
            if (mst_valid_i) begin
               state_d = dec_hit ? S_BUSY : S_ERR;
            end
         end
         S_BUSY: begin
            slv_valid_o = sel_q;
            if (sel_ready || timeout) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            mst_ready_o = 1'b1;
            mst_err_o   = err_q;
            state_d     = S_IDLE;
         end
         S_ERR: begin
            mst_ready_o = 1'b1;
            mst_err_o   = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Request latch, slave select, response data and error flag.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         slv_addr_o  <= '0;
         slv_wdata_o <= '0;
         slv_wstrb_o <= '0;
         sel_q       <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (mst_valid_i) begin
                  slv_addr_o  <= mst_addr_i;
                  slv_wdata_o <= mst_wdata_i;
                  slv_wstrb_o <= mst_wstrb_i;
                  sel_q       <= dec_sel;
                  err_q       <= 1'b0;
                  // The unmapped response goes out in the ERR cycle, so load its data now.
                  if (!dec_hit) begin
                     rdata_q <= ERR_RDATA;
                  end
               end
            end
            S_BUSY: begin
               // Ready has priority over an expiry on the same cycle.
               if (sel_ready) begin
                  rdata_q <= sel_rdata;
               end else if (timeout) begin
                  rdata_q <= ERR_RDATA;
                  err_q   <= 1'b1;
               end
            end
            S_RESP: begin
               err_q <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   assign mst_rdata_o = rdata_q;

   // STRB_W documents the strobe width; the ports use the expression directly.
   if (STRB_W < 1) begin : g_bad_strb
      $error("nmi_demux_bus: DATA_W too small");
   end

endmodule

// File: tb/tb_nmi_demux_bus.sv
// tb_nmi_demux_bus: self-checking bench for nmi_demux_bus.
// Slaves are modelled cycle by cycle. The bench keeps its own address map and
// latency/response rules to derive expected results.
module tb_nmi_demux_bus;

   localparam int NS = 8;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;
   localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
`ifdef NMI_DEMUX_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   // Slave 4 duplicates slave 1's entry to exercise overlap priority.
   localparam logic [NS*AW-1:0] BASE = {32'h1700_0000, 32'h1600_0000, 32'h1500_0000, 32'h1100_0000,
                                        32'h1300_0000, 32'h1200_0000, 32'h1100_0000, 32'h1000_0000};
   localparam logic [NS*AW-1:0] MASK = {NS{32'hFF00_0000}};

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          mst_valid = 1'b0;
   logic [31:0]   mst_addr = '0;
   logic [31:0]   mst_wdata = '0;
   logic [3:0]    mst_wstrb = '0;
   logic [31:0]   mst_rdata_o;
   logic          mst_ready_o;
   logic          mst_err_o;
   logic [NS-1:0] slv_valid_o;
   logic [31:0]   slv_addr_o;
   logic [31:0]   slv_wdata_o;
   logic [3:0]    slv_wstrb_o;
   logic [NS*DW-1:0] slv_rdata = '0;
   logic [NS-1:0] slv_ready = '0;

   int checks = 0;
   int errors = 0;
   logic [31:0] mbase [NS];
   logic [31:0] mmask [NS];

   nmi_demux_bus #(
      .NUM_SLV(NS), .ADDR_W(AW), .DATA_W(DW), .SLV_BASE(BASE), .SLV_MASK(MASK),
      .TIMEOUT_CYC(TO), .ERR_RDATA(ERRD)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .mst_valid_i(mst_valid), .mst_addr_i(mst_addr), .mst_wdata_i(mst_wdata),
      .mst_wstrb_i(mst_wstrb), .mst_rdata_o(mst_rdata_o), .mst_ready_o(mst_ready_o),
      .mst_err_o(mst_err_o), .slv_valid_o(slv_valid_o), .slv_addr_o(slv_addr_o),
      .slv_wdata_o(slv_wdata_o), .slv_wstrb_o(slv_wstrb_o), .slv_rdata_i(slv_rdata),
      .slv_ready_i(slv_ready)
   );

   always #5 clk = ~clk;

   // Reference decode: first table entry whose masked base matches, else -1.
   function automatic int model_decode(input logic [31:0] a);
      for (int i = 0; i < NS; i++) begin
         if ((a & mmask[i]) == (mbase[i] & mmask[i])) return i;
      end
      return -1;
   endfunction

   // Slave-valid cycles for a slave answering d cycles after valid rises.
   function automatic int exp_vld(input int d);
      if (TO_EN && d + 1 > TO) return TO;
      return d + 1;
   endfunction

   // Drives one master request and plays the slaves. Non-target slaves toggle ready
   // and rdata randomly. Reports what the DUT showed; the caller judges the result.
   task automatic run_txn(
      input  logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
      input  int tgt, input int d, input logic [31:0] sdata, input bit scramble, input bit keep,
      output int lat, output int vcnt, output int fvld, output logic [7:0] fvec,
      output logic [31:0] rd, output logic er, output logic [31:0] oaddr,
      output logic [31:0] owdata, output logic [3:0] owstrb, output bit badv,
      output logic rdy2, output logic [31:0] rdh);
      logic [7:0] m;
      int c;
      m = (tgt >= 0) ? 8'(1 << tgt) : 8'h00;
      lat = -1; vcnt = 0; fvld = -1; fvec = '0; rd = '0; er = 1'b0;
      oaddr = '0; owdata = '0; owstrb = '0; badv = 1'b0; rdy2 = 1'b0; rdh = '0;
      mst_valid = 1'b1; mst_addr = addr; mst_wdata = wdata; mst_wstrb = wstrb;
      c = 0;
      while (c < 300 && lat < 0) begin
         @(posedge clk); #1; c++;
         if (mst_ready_o) begin
            lat = c; rd = mst_rdata_o; er = mst_err_o;
            if (slv_valid_o != 0) badv = 1'b1;
         end else if (slv_valid_o != 0) begin
            if (slv_valid_o !== m) badv = 1'b1;
            vcnt++;
            if (fvld < 0) begin
               fvld = c; fvec = slv_valid_o; oaddr = slv_addr_o; owdata = slv_wdata_o; owstrb = slv_wstrb_o;
            end
         end
         slv_ready = 8'($urandom) & ~m;
         for (int i = 0; i < NS; i++) slv_rdata[i*DW +: DW] = $urandom;
         if (tgt >= 0) slv_rdata[tgt*DW +: DW] = sdata;
         if (lat < 0 && tgt >= 0 && slv_valid_o == m && vcnt == d + 1) slv_ready[tgt] = 1'b1;
         if (scramble && lat < 0) begin
            mst_addr = $urandom; mst_wdata = $urandom; mst_wstrb = 4'($urandom); mst_valid = 1'($urandom);
         end
      end
      slv_ready = '0;
      mst_valid = keep;
      if (!keep) begin
         @(posedge clk); #1;
         rdy2 = mst_ready_o; rdh = mst_rdata_o;
      end else begin
         rdh = rd;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({mst_ready_o, mst_err_o, mst_rdata_o, slv_valid_o, slv_addr_o, slv_wdata_o, slv_wstrb_o} !== '0) begin
         errors++; $display("FAIL reset_outputs: got ready=%b err=%b rdata=%h valid=%b addr=%h, want all 0",
                            mst_ready_o, mst_err_o, mst_rdata_o, slv_valid_o, slv_addr_o);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({mst_ready_o, slv_valid_o} !== '0) begin
         errors++; $display("FAIL idle_after_reset: got ready=%b valid=%b, want 0", mst_ready_o, slv_valid_o);
      end
   endtask

   task automatic test_decode_write();
      int lat, vc, fv; logic [7:0] fvec; logic [31:0] rd, oa, ow, rdh; logic er, r2; logic [3:0] os; bit bv;
      run_txn(32'h1300_0004, 32'hA5A5_0001, 4'hF, model_decode(32'h1300_0004), 2, 32'h0, 0, 0,
              lat, vc, fv, fvec, rd, er, oa, ow, os, bv, r2, rdh);
      checks++; if (fvec !== 8'h08 || bv) begin errors++; $display("FAIL write_sel: got %h bad=%0d want 08", fvec, bv); end
      checks++; if (oa !== 32'h1300_0004 || ow !== 32'hA5A5_0001 || os !== 4'hF) begin
         errors++; $display("FAIL write_fields: got %h %h %h want 13000004 a5a50001 f", oa, ow, os); end
      checks++; if (lat !== 4 || fv !== 1) begin errors++; $display("FAIL write_latency: got %0d/%0d want 4/1", lat, fv); end
      checks++; if (er !== 1'b0 || r2 !== 1'b0) begin errors++; $display("FAIL write_err_pulse: got err=%b ready2=%b want 0 0", er, r2); end
   endtask

   task automatic test_read();
      int lat, vc, fv; logic [7:0] fvec; logic [31:0] rd, oa, ow, rdh; logic er, r2; logic [3:0] os; bit bv;
      run_txn(32'h1500_0000, 32'h0, 4'h0, model_decode(32'h1500_0000), 0, 32'h1234_5678, 0, 0,
              lat, vc, fv, fvec, rd, er, oa, ow, os, bv, r2, rdh);
      checks++; if (rd !== 32'h1234_5678 || er !== 1'b0) begin errors++; $display("FAIL read_data: got %h err=%b want 12345678 0", rd, er); end
      checks++; if (fvec !== 8'h20 || lat !== 2 || os !== 4'h0) begin
         errors++; $display("FAIL read_sel_lat: got sel=%h lat=%0d strb=%h want 20 2 0", fvec, lat, os); end
      checks++; if (rdh !== 32'h1234_5678 || r2 !== 1'b0) begin errors++; $display("FAIL read_hold: got %h ready=%b want 12345678 0", rdh, r2); end
   endtask

   task automatic test_unmapped();
      int lat, vc, fv; logic [7:0] fvec; logic [31:0] rd, oa, ow, rdh; logic er, r2; logic [3:0] os; bit bv;
      run_txn(32'hF000_0000, 32'h0, 4'h0, model_decode(32'hF000_0000), 0, 32'h0, 0, 0,
              lat, vc, fv, fvec, rd, er, oa, ow, os, bv, r2, rdh);
      checks++; if (lat !== 1 || vc !== 0 || bv) begin errors++; $display("FAIL unmapped_timing: got lat=%0d vld=%0d want 1 0", lat, vc); end
      checks++; if (er !== 1'b1 || rd !== ERRD) begin errors++; $display("FAIL unmapped_resp: got err=%b rdata=%h want 1 deadbeef", er, rd); end
   endtask

   task automatic test_timeout();
      int lat, vc, fv; logic [7:0] fvec; logic [31:0] rd, oa, ow, rdh; logic er, r2; logic [3:0] os; bit bv;
      int ds [3] = '{100, 15, 16};
      for (int k = 0; k < 3; k++) begin
         int ev; bit to;
         ev = exp_vld(ds[k]); to = (ev < ds[k] + 1);
         run_txn(32'h1200_0020, 32'h0, 4'h0, 2, ds[k], 32'h0BAD_F00D + k, 0, 0,
                 lat, vc, fv, fvec, rd, er, oa, ow, os, bv, r2, rdh);
         checks++; if (vc !== ev || lat !== ev + 1) begin
            errors++; $display("FAIL timeout_len d=%0d: got vld=%0d lat=%0d want %0d %0d", ds[k], vc, lat, ev, ev + 1); end
         checks++; if (er !== to || rd !== (to ? ERRD : 32'h0BAD_F00D + k)) begin
            errors++; $display("FAIL timeout_resp d=%0d: got err=%b rdata=%h want %b", ds[k], er, rd, to); end
      end
   endtask

   task automatic test_overlap();
      int lat, vc, fv; logic [7:0] fvec; logic [31:0] rd, oa, ow, rdh; logic er, r2; logic [3:0] os; bit bv;
      run_txn(32'h1100_00AC, 32'h0, 4'h0, model_decode(32'h1100_00AC), 1, 32'h5151_1111, 0, 0,
              lat, vc, fv, fvec, rd, er, oa, ow, os, bv, r2, rdh);
      checks++; if (fvec !== 8'h02 || bv || rd !== 32'h5151_1111) begin
         errors++; $display("FAIL overlap_sel: got sel=%h rdata=%h want 02 51511111", fvec, rd); end
   endtask

   task automatic test_back_to_back();
      int lat, vc, fv; logic [7:0] fvec; logic [31:0] rd, oa, ow, rdh; logic er, r2; logic [3:0] os; bit bv;
      run_txn(32'h1000_0010, 32'h1, 4'h3, 0, 1, 32'hAAAA_0000, 0, 1,
              lat, vc, fv, fvec, rd, er, oa, ow, os, bv, r2, rdh);
      checks++; if (lat !== 3 || rd !== 32'hAAAA_0000) begin errors++; $display("FAIL b2b_first: got lat=%0d rdata=%h want 3 aaaa0000", lat, rd); end
      run_txn(32'h1700_0030, 32'h2, 4'hC, 7, 0, 32'hBBBB_0000, 0, 0,
              lat, vc, fv, fvec, rd, er, oa, ow, os, bv, r2, rdh);
      checks++; if (fv !== 2 || lat !== 3 || fvec !== 8'h80) begin
         errors++; $display("FAIL b2b_bubble: got first_vld=%0d lat=%0d sel=%h want 2 3 80", fv, lat, fvec); end
      checks++; if (rd !== 32'hBBBB_0000 || oa !== 32'h1700_0030) begin errors++; $display("FAIL b2b_second: got %h %h", rd, oa); end
   endtask

   task automatic test_reset_mid_busy();
      int lat, vc, fv; logic [7:0] fvec; logic [31:0] rd, oa, ow, rdh; logic er, r2; logic [3:0] os; bit bv;
      bit seen;
      mst_valid = 1'b1; mst_addr = 32'h1200_0010; mst_wdata = 32'h7777_7777; mst_wstrb = 4'hF;
      repeat (4) @(posedge clk);
      #1;
      checks++; if (slv_valid_o !== 8'h04) begin errors++; $display("FAIL midrst_busy: got %h want 04", slv_valid_o); end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({mst_ready_o, mst_err_o, mst_rdata_o, slv_valid_o, slv_addr_o, slv_wdata_o, slv_wstrb_o} !== '0) begin
         errors++; $display("FAIL midrst_outputs: got valid=%h addr=%h ready=%b want 0", slv_valid_o, slv_addr_o, mst_ready_o);
      end
      mst_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 1'b0;
      repeat (20) begin
         @(posedge clk); #1;
         if (mst_ready_o || slv_valid_o != 0) seen = 1'b1;
      end
      checks++; if (seen) begin errors++; $display("FAIL midrst_silent: got activity after reset, want none"); end
      run_txn(32'h1600_0040, 32'h0, 4'h0, 6, 1, 32'hC0DE_0006, 0, 0,
              lat, vc, fv, fvec, rd, er, oa, ow, os, bv, r2, rdh);
      checks++; if (lat !== 3 || rd !== 32'hC0DE_0006 || er !== 1'b0) begin
         errors++; $display("FAIL midrst_recover: got lat=%0d rdata=%h err=%b want 3 c0de0006 0", lat, rd, er); end
   endtask

   task automatic test_random();
      int lat, vc, fv; logic [7:0] fvec; logic [31:0] rd, oa, ow, rdh; logic er, r2; logic [3:0] os; bit bv;
      for (int n = 0; n < 40; n++) begin
         logic [31:0] a, wd, sd; logic [3:0] ws; int idx, d, ev, elat; bit scr, to; logic [31:0] erd; logic eer;
         a   = {8'($urandom_range(8'h19, 8'h0E)), 24'($urandom)};
         wd  = $urandom; sd = $urandom;
         ws  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         d   = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 5);
         scr = ($urandom_range(0, 3) == 0);
         idx = model_decode(a);
         if (idx < 0) begin
            ev = 0; elat = 1; erd = ERRD; eer = 1'b1;
         end else begin
            ev = exp_vld(d); to = (ev < d + 1); elat = ev + 1; erd = to ? ERRD : sd; eer = to;
         end
         run_txn(a, wd, ws, idx, d, sd, scr, 0, lat, vc, fv, fvec, rd, er, oa, ow, os, bv, r2, rdh);
         checks++; if (lat !== elat || vc !== ev || bv) begin
            errors++; $display("FAIL rnd%0d_timing a=%h d=%0d: got lat=%0d vld=%0d bad=%0d want %0d %0d", n, a, d, lat, vc, bv, elat, ev); end
         checks++; if (rd !== erd || er !== eer) begin
            errors++; $display("FAIL rnd%0d_resp a=%h: got %h err=%b want %h %b", n, a, rd, er, erd, eer); end
         checks++; if (r2 !== 1'b0 || rdh !== erd) begin
            errors++; $display("FAIL rnd%0d_hold: got ready=%b rdata=%h want 0 %h", n, r2, rdh, erd); end
         if (idx >= 0) begin
            checks++; if (oa !== a || ow !== wd || os !== ws) begin
               errors++; $display("FAIL rnd%0d_fields: got %h %h %h want %h %h %h", n, oa, ow, os, a, wd, ws); end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < NS; i++) begin
         mbase[i] = 32'h1000_0000 | (32'(i) << 24);
         mmask[i] = 32'hFF00_0000;
      end
      mbase[4] = mbase[1];
      test_reset();
      test_decode_write();
      test_read();
      test_unmapped();
      test_timeout();
      test_overlap();
      test_back_to_back();
      test_reset_mid_busy();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_time_limit: simulation did not complete, checks=%0d", checks);
      $fatal(1, "time limit");
   end

endmodule
